// File: rtl/zxw_display_arbiter.sv
// -----------------------------------------------------------------------------
// zxw_display_arbiter
//
// Round-robin owner of the single 8-bit seven-segment display. Four pattern
// generators request the display with level-sensitive Req lines; the winner
// owns Display_out for a fixed hold window of HOLD_CYCLES clocks. After that,
// ownership rotates to the next requester after the current one.
//
// Optional feature macro: DISPLAY_BLANK_EN
//   When defined, every release is followed by BLANK_CYCLES cycles of forced
//   blank output (8'hFF, no grant, Req ignored) to avoid ghosting between two
//   owners' patterns. When undefined, the BLANK state and its counter are not
//   built and release returns straight to IDLE.
//
// Parameters:
//   HOLD_CYCLES  - cycles an owner keeps the display (1..255)
//   BLANK_CYCLES - blanking gap between owners (1..15), DISPLAY_BLANK_EN only
//
// Ports:
//   Clock       in   1  single clock, rising-edge
//   Reset       in   1  asynchronous, active-high reset
//   Req         in   4  per-requester request level
//   Seg_in      in  32  segment lanes, requester k on [8k+7:8k], active-low
//   Grant       out  4  one-hot current owner, zero when nobody owns
//   Owner       out  2  index of the current / most recent owner
//   Done        out  1  one-cycle pulse after a hold window runs to completion
//   Display_out out  8  registered active-low segments, 8'hFF = blank
// -----------------------------------------------------------------------------
module zxw_display_arbiter #(
  parameter int HOLD_CYCLES  = 25,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [31:0] Seg_in,
  output logic [3:0]  Grant,
  output logic [1:0]  Owner,
  output logic        Done,
  output logic [7:0]  Display_out
);

  // ---------------------------------------------------------------------------
  // Parameter range guards (elaboration time only)
  // ---------------------------------------------------------------------------
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("zxw_display_arbiter: HOLD_CYCLES must be in 1..255");
  end

  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 15) begin : g_bad_blank
    $error("zxw_display_arbiter: BLANK_CYCLES must be in 1..15");
  end

  localparam logic [7:0] BLANK_SEG = 8'hFF;

  // The hold counter is loaded with N-1 on the grant edge and release happens
  // on the edge that sees it at zero, so the grant lasts exactly N cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

`ifdef DISPLAY_BLANK_EN
  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1
`ifdef DISPLAY_BLANK_EN
   ,ST_BLANK = 2'd2
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic        done_q,  done_d;
  logic [7:0]  disp_q,  disp_d;
  logic [1:0]  last_q,  last_d;
  logic [7:0]  cnt_q,   cnt_d;
`ifdef DISPLAY_BLANK_EN
  logic [3:0]  blank_q, blank_d;
`endif

  // Arbitration result
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        win_found;

  // Where the FSM goes once an owner lets go of the display.
`ifdef DISPLAY_BLANK_EN
  localparam state_t REL_STATE = ST_BLANK;
`else
  localparam state_t REL_STATE = ST_IDLE;
`endif

  function automatic logic [7:0] lane_of(input logic [31:0] seg,
                                         input logic [1:0]  k);
    return seg[{k, 3'b000} +: 8];
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester strictly after last_q, wrapping.
  // Offset 4 wraps back to last_q itself, so a lone requester that just
  // released can win again.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a value before any branch,
    // otherwise synthesis infers a latch to hold it on the untaken paths.
    win_idx   = last_q;
    win_found = 1'b0;
    cand      = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + i[1:0];
      if (!win_found && Req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    done_d  = 1'b0;
    disp_d  = disp_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef DISPLAY_BLANK_EN
    blank_d = blank_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        grant_d = 4'b0000;
        disp_d  = BLANK_SEG;
        if (win_found) begin
          state_d = ST_HOLD;
          grant_d = 4'b0001 << win_idx;
          owner_d = win_idx;
          cnt_d   = HOLD_LOAD;
          // The winner's pattern is already visible after the grant edge.
          disp_d  = lane_of(Seg_in, win_idx);
        end
      end

      ST_HOLD: begin
        disp_d = lane_of(Seg_in, owner_q);
        // Expiry is tested first so a Req drop on the final edge still
        // counts as a completed window.
        if (cnt_q == 8'd0 || !Req[owner_q]) begin
          state_d = REL_STATE;
          done_d  = (cnt_q == 8'd0);
          grant_d = 4'b0000;
          last_d  = owner_q;
          cnt_d   = 8'd0;
          disp_d  = BLANK_SEG;
`ifdef DISPLAY_BLANK_EN
          blank_d = BLANK_LOAD;
`endif
        end else begin
          // Only reached with cnt_q != 0, so the counter never wraps.
          cnt_d = cnt_q - 8'd1;
        end
      end

`ifdef DISPLAY_BLANK_EN
      ST_BLANK: begin
        grant_d = 4'b0000;
        disp_d  = BLANK_SEG;
        if (blank_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          blank_d = blank_q - 4'd1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        disp_d  = BLANK_SEG;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      owner_q <= 2'd0;
      done_q  <= 1'b0;
      disp_q  <= BLANK_SEG;
      last_q  <= 2'd3;      // requester 0 has first priority after reset
      cnt_q   <= 8'd0;
`ifdef DISPLAY_BLANK_EN
      blank_q <= 4'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
`ifdef DISPLAY_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  assign Grant       = grant_q;
  assign Owner       = owner_q;
  assign Done        = done_q;
  assign Display_out = disp_q;

endmodule

// File: tb/tb_zxw_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zxw_display_arbiter
//
// Directed bench for zxw_display_arbiter with HOLD_CYCLES = 4, BLANK_CYCLES = 2.
// Each step drives Req (and Seg_in), queues the outputs expected after the
// next rising edge, then checks them on the following falling edge.
// Works with and without DISPLAY_BLANK_EN (gap between grants adapts).
// -----------------------------------------------------------------------------
module tb_zxw_display_arbiter;

  localparam int HOLD  = 4;
  localparam int BLANK = 2;
`ifdef DISPLAY_BLANK_EN
  localparam int GAP = BLANK + 1;
`else
  localparam int GAP = 1;
`endif

  localparam logic [7:0] L0 = 8'hC0;
  localparam logic [7:0] L1 = 8'hF9;
  localparam logic [7:0] L2 = 8'hA4;
  localparam logic [7:0] L3 = 8'hB0;
  localparam logic [7:0] FF = 8'hFF;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [3:0]  Req;
  logic [31:0] Seg_in;
  logic [3:0]  Grant;
  logic [1:0]  Owner;
  logic        Done;
  logic [7:0]  Display_out;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       done;
    logic [7:0] disp;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  zxw_display_arbiter #(
    .HOLD_CYCLES (HOLD),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .Seg_in     (Seg_in),
    .Grant      (Grant),
    .Owner      (Owner),
    .Done       (Done),
    .Display_out(Display_out)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %02h required %02h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk("grant", {4'b0000, Grant}, {4'b0000, e.grant});
    chk("owner", {6'b000000, Owner}, {6'b000000, e.owner});
    chk("done",  {7'b0000000, Done}, {7'b0000000, e.done});
    chk("disp",  Display_out, e.disp);
  endtask

  // One clock: drive Req, queue the expectation, check after the edge.
  task automatic step(input logic [3:0] req, input logic [3:0] g,
                      input logic [1:0] o, input logic d, input logic [7:0] disp);
    exp_t e;
    Req = req;
    sb.push_back('{grant: g, owner: o, done: d, disp: disp});
    @(posedge Clock);
    @(negedge Clock);
    e = sb.pop_front();
    check_outputs(e);
  endtask

  logic [7:0] lanes [4];
  logic [1:0] ix;
  logic [3:0] oh;
  exp_t       rst_exp;

  initial begin
    lanes[0] = L0; lanes[1] = L1; lanes[2] = L2; lanes[3] = L3;
    rst_exp  = '{grant: 4'b0000, owner: 2'd0, done: 1'b0, disp: FF};

    // ---- reset values ------------------------------------------------------
    phase  = "reset";
    Reset  = 1'b1;
    Req    = 4'b0000;
    Seg_in = {L3, L2, L1, L0};
    #1;
    check_outputs(rst_exp);
    @(negedge Clock);
    Reset = 1'b0;

    // ---- single requester, with Seg_in lag check ---------------------------
    phase = "single";
    step(4'b0100, 4'b0100, 2'd2, 1'b0, L2);
    step(4'b0100, 4'b0100, 2'd2, 1'b0, L2);
    Seg_in[23:16] = 8'h99;
    step(4'b0100, 4'b0100, 2'd2, 1'b0, 8'h99);
    Seg_in[23:16] = L2;
    step(4'b0100, 4'b0100, 2'd2, 1'b0, L2);
    step(4'b0100, 4'b0000, 2'd2, 1'b1, FF);
    step(4'b0000, 4'b0000, 2'd2, 1'b0, FF);
    repeat (GAP) step(4'b0000, 4'b0000, 2'd2, 1'b0, FF);

    // ---- expiry collides with Req drop: Done still pulses ------------------
    phase = "collision";
    repeat (HOLD) step(4'b1000, 4'b1000, 2'd3, 1'b0, L3);
    step(4'b0000, 4'b0000, 2'd3, 1'b1, FF);
    repeat (GAP) step(4'b0000, 4'b0000, 2'd3, 1'b0, FF);

    // ---- early release after 2 granted cycles ------------------------------
    phase = "early";
    step(4'b0010, 4'b0010, 2'd1, 1'b0, L1);
    step(4'b0010, 4'b0010, 2'd1, 1'b0, L1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0, FF);
    repeat (GAP) step(4'b0000, 4'b0000, 2'd1, 1'b0, FF);

    // ---- next search starts at 2 (0 also requesting), then rotates to 0 ----
    phase = "rr_from2";
    repeat (HOLD) step(4'b0101, 4'b0100, 2'd2, 1'b0, L2);
    step(4'b0101, 4'b0000, 2'd2, 1'b1, FF);
    repeat (GAP - 1) step(4'b0101, 4'b0000, 2'd2, 1'b0, FF);
    repeat (HOLD) step(4'b0101, 4'b0001, 2'd0, 1'b0, L0);
    step(4'b0000, 4'b0000, 2'd0, 1'b1, FF);
    repeat (GAP) step(4'b0000, 4'b0000, 2'd0, 1'b0, FF);

    // ---- late request from 0 during 3's hold: no preemption ----------------
    phase = "late";
    step(4'b1000, 4'b1000, 2'd3, 1'b0, L3);
    repeat (HOLD - 1) step(4'b1001, 4'b1000, 2'd3, 1'b0, L3);
    step(4'b1001, 4'b0000, 2'd3, 1'b1, FF);
    repeat (GAP - 1) step(4'b1001, 4'b0000, 2'd3, 1'b0, FF);
    repeat (HOLD) step(4'b0001, 4'b0001, 2'd0, 1'b0, L0);
    step(4'b0000, 4'b0000, 2'd0, 1'b1, FF);
    repeat (GAP) step(4'b0000, 4'b0000, 2'd0, 1'b0, FF);

    // ---- asynchronous reset in the middle of a hold ------------------------
    phase = "reset_mid";
    step(4'b0010, 4'b0010, 2'd1, 1'b0, L1);
    step(4'b0010, 4'b0010, 2'd1, 1'b0, L1);
    #1 Reset = 1'b1;
    #1;
    check_outputs(rst_exp);
    Req = 4'b1111;
    @(negedge Clock);
    Reset = 1'b0;

    // ---- fairness: all four requesting, order 0,1,2,3,0 --------------------
    phase = "fair";
    for (int k = 0; k < 5; k++) begin
      ix = 2'(k % 4);
      oh = 4'b0001 << ix;
      repeat (HOLD) step(4'b1111, oh, ix, 1'b0, lanes[ix]);
      step(4'b1111, 4'b0000, ix, 1'b1, FF);
      repeat (GAP - 1) step(4'b1111, 4'b0000, ix, 1'b0, FF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zxw_display_arbiter.md
# zxw_display_arbiter

Round-robin arbiter/scheduler that shares the single 8-bit seven-segment output of the lab display datapath among four requesters. Each granted requester owns `Display_out` for a fixed hold window, and the arbiter then rotates ownership. The block sits between the per-function pattern generators (counters, message ROMs, switch decoders) and the board's display pins. It replaces ad-hoc muxing in the lab top level.

## Interface
Parameters:
- `HOLD_CYCLES`, default 25: clock cycles an owner keeps the display; legal range 1..255.
- `BLANK_CYCLES`, default 2: blanking gap between owners; legal range 1..15; used only with `DISPLAY_BLANK_EN`.

Ports:
- `Clock`, in, 1: single clock; all state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Req`, in, 4: request line per requester; level-sensitive; held high while the requester wants the display.
- `Seg_in`, in, 32: segment lanes; requester k drives `[8k+7:8k]`; active-low; bit 7 of each lane is dp.
- `Grant`, out, 4: one-hot owner indication; all zero when no owner.
- `Owner`, out, 2: encoded index of the last/current owner.
- `Done`, out, 1: one-cycle pulse when a hold window completes in full.
- `Display_out`, out, 8: registered, active-low segments; `8'hFF` means blank.

## Operation
- States: IDLE, HOLD, BLANK (BLANK exists only with `DISPLAY_BLANK_EN`).
- Round-robin pointer `last` (2 bits). After reset `last` = 3, so requester 0 has first priority.
- IDLE:
  - `Display_out` = `8'hFF`, `Grant` = 0.
  - When any `Req` bit is high at an edge, the winner is the first requesting index searched from `last+1` upward, wrapping modulo 4.
  - On that edge: `Grant` is set to the winner's one-hot, `Owner` = winner, the down-counter is loaded with `HOLD_CYCLES-1`, and the state goes to HOLD.
- HOLD:
  - `Display_out` is loaded every edge from the owner's lane, including the grant edge.
  - The counter decrements each edge.
  - Expiry: at the edge where the counter = 0, `Grant` clears, `last` = owner, `Done` is set for one cycle, and the state goes to BLANK (or IDLE without the macro).
  - Early release: if the owner's `Req` is low at an edge with counter ≠ 0, `Grant` clears, `last` = owner, `Done` stays 0, and the state goes to BLANK or IDLE.
  - Simultaneous expiry and `Req` drop: expiry wins, so `Done` pulses.
- Non-owner `Req` changes during HOLD or BLANK are ignored. Arbitration happens only from IDLE.
- `Owner` holds its value after release until the next grant. Reset value is 0.
- Counter width is 8 bits, saturating at 0. It never wraps.

## Timing
- Reset (asynchronous, immediate, any state): state = IDLE, `Grant` = 0, `Owner` = 0, `Done` = 0, `Display_out` = `8'hFF`, `last` = 3, counter = 0.
- Request-to-grant latency: 1 edge from IDLE. `Req` high before edge t gives `Grant` and `Display_out` valid after edge t.
- `Grant` is high for exactly `HOLD_CYCLES` cycles on full completion.
- `Display_out` lags `Seg_in` by one cycle while granted.
- `Done` is high for the single cycle right after the last HOLD cycle, coincident with `Grant` = 0.
- Minimum gap between consecutive grants:
  - Without macro: 1 IDLE cycle.
  - With macro: `BLANK_CYCLES` + 1 cycles.
- With all four requesters continuously requesting, the service order is 0,1,2,3,0,…

## Configuration
- `DISPLAY_BLANK_EN` defined:
  - After every release the arbiter spends exactly `BLANK_CYCLES` cycles in BLANK, with `Display_out` = `8'hFF` and `Grant` = 0, then goes to IDLE.
  - `Req` is ignored during BLANK.
  - Purpose: prevents ghosting between patterns.
- Not defined: the BLANK state and its counter are not built, and release goes directly to IDLE.

## Test plan
Bench settings: `HOLD_CYCLES` = 4, `BLANK_CYCLES` = 2.
- Reset mid-operation: `Reset` pulse during HOLD → all outputs at reset values within the same cycle, no clock needed; the next grant goes to requester 0 if requested.
- Single requester: `Req` = `4'b0100`, `Seg_in[23:16]` = `8'hA4` → `Grant` = `4'b0100` and `Display_out` = `8'hA4` for 4 cycles, `Owner` = 2; `Done` pulses once, then `Display_out` = `8'hFF`.
- Fairness: `Req` = `4'b1111` held for 40 cycles → grant order 0,1,2,3,0; each grant lasts 4 cycles; gaps are 1 cycle (3 with `DISPLAY_BLANK_EN`).
- Early release: requester 1 drops `Req` after 2 granted cycles → `Grant` clears at that edge, `Done` stays 0, and the next grant searches from index 2.
- Expiry collision: the owner drops `Req` on the edge where the counter hits 0 → `Done` = 1 for one cycle.
- Ignored late request: requester 0 raises `Req` mid-HOLD of requester 3 → no preemption; requester 0 is granted 1 cycle after requester 3's release (+2 with the macro).
